// File: rtl/time_set_controller.sv
// mm:ss time keeper with two-button set mode and field blink; press reaches outputs DEBOUNCE_CYCLES+3 edges after raw rise.
// No backpressure: tick and button events are consumed in the cycle they appear.
module time_set_controller #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] BLINK_CYCLES    = 24'd6250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic [3:0] blank_mask,
  output logic       set_active
);

  typedef enum logic [1:0] {RUN, SET_MIN, SET_SEC} state_t;

  state_t      state, state_nxt;
  logic        mode_press, inc_press;
  logic [23:0] blink_cnt, blink_cnt_nxt;
  logic        blink_phase, blink_phase_nxt;
  logic [7:0]  minutes_nxt, seconds_nxt;
  logic [3:0]  blank_nxt;

  tsc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_mode),
    .press (mode_press)
  );

  tsc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_inc),
    .press (inc_press)
  );

  function automatic logic [7:0] wrap59(input logic [7:0] v);
    return (v == 8'd59) ? 8'd0 : v + 8'd1;
  endfunction

  always_comb begin
    state_nxt       = state;
    minutes_nxt     = minutes;
    seconds_nxt     = seconds;
    blink_cnt_nxt   = 24'd0;
    blink_phase_nxt = 1'b0;
    blank_nxt       = 4'b0000;

    // mode outranks inc; in RUN a coincident tick still lands
    case (state)
      RUN: begin
        if (tick_1hz) begin
          seconds_nxt = wrap59(seconds);
          if (seconds == 8'd59) minutes_nxt = wrap59(minutes);
        end
        if (mode_press) state_nxt = SET_MIN;
      end
      SET_MIN: begin
        if (mode_press)     state_nxt   = SET_SEC;
        else if (inc_press) minutes_nxt = wrap59(minutes);
      end
      SET_SEC: begin
        if (mode_press)     state_nxt   = RUN;
        else if (inc_press) seconds_nxt = wrap59(seconds);
      end
      default: state_nxt = RUN;
    endcase

    if (state_nxt == state && state != RUN) begin
      if (blink_cnt == BLINK_CYCLES - 24'd1) begin
        blink_cnt_nxt   = 24'd0;
        blink_phase_nxt = ~blink_phase;
      end else begin
        blink_cnt_nxt   = blink_cnt + 24'd1;
        blink_phase_nxt = blink_phase;
      end
    end

    if (blink_phase_nxt && state_nxt == SET_MIN) blank_nxt = 4'b1100;
    if (blink_phase_nxt && state_nxt == SET_SEC) blank_nxt = 4'b0011;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      minutes     <= 8'd0;
      seconds     <= 8'd0;
      blink_cnt   <= 24'd0;
      blink_phase <= 1'b0;
      blank_mask  <= 4'b0000;
      set_active  <= 1'b0;
    end else begin
      state       <= state_nxt;
      minutes     <= minutes_nxt;
      seconds     <= seconds_nxt;
      blink_cnt   <= blink_cnt_nxt;
      blink_phase <= blink_phase_nxt;
      blank_mask  <= blank_nxt;
      set_active  <= (state_nxt != RUN);
    end
  end

endmodule

// Button synchronizer + debouncer; press is a 1-cycle pulse on the debounced rising edge.
// Latency CYCLES+2 edges from raw rise to press; no backpressure.
module tsc_debounce #(
  parameter logic [15:0] CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  logic [1:0]  sync;
  logic        level;
  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync  <= 2'b00;
      level <= 1'b0;
      cnt   <= 16'd0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= 16'd0;
      end else if (cnt == CYCLES - 16'd1) begin
        level <= sync[1];
        cnt   <= 16'd0;
        press <= sync[1];
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_time_set_controller.sv
// Scoreboard bench for time_set_controller with short debounce/blink periods.
module tb_time_set_controller;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n, tick_1hz, btn_mode, btn_inc;
  logic [7:0] minutes, seconds;
  logic [3:0] blank_mask;
  logic       set_active;

  always #5 clk = ~clk;

  time_set_controller #(.DEBOUNCE_CYCLES(16'd4), .BLINK_CYCLES(24'd8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_1hz   (tick_1hz),
    .btn_mode   (btn_mode),
    .btn_inc    (btn_inc),
    .minutes    (minutes),
    .seconds    (seconds),
    .blank_mask (blank_mask),
    .set_active (set_active)
  );

  typedef struct {
    int mn;
    int sc;
    int mask;
    bit chk_mask;
    int act;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_min, m_sec, m_st;   // model: st 0=RUN 1=SET_MIN 2=SET_SEC

  task automatic check_val(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int wrap_inc(input int v);
    return (v == 59) ? 0 : v + 1;
  endfunction

  task automatic expect_now(input int mask, input bit chk_mask);
    exp_t e;
    e.mn = m_min; e.sc = m_sec; e.mask = mask; e.chk_mask = chk_mask;
    e.act = (m_st != 0) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    check_val({tag, ".sb_depth"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_val({tag, ".min"}, int'(minutes), e.mn);
      check_val({tag, ".sec"}, int'(seconds), e.sc);
      check_val({tag, ".act"}, int'(set_active), e.act);
      if (e.chk_mask) check_val({tag, ".mask"}, int'(blank_mask), e.mask);
    end
  endtask

  task automatic do_press(input string tag, input bit mode, input bit inc);
    if (mode)               m_st = (m_st + 1) % 3;
    else if (inc && m_st == 1) m_min = wrap_inc(m_min);
    else if (inc && m_st == 2) m_sec = wrap_inc(m_sec);
    expect_now(0, m_st == 0);
    btn_mode = mode;
    btn_inc  = inc;
    repeat (D + 4) step();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (D + 4) step();
    compare_out(tag);
  endtask

  task automatic do_tick(input string tag);
    if (m_st == 0) begin
      if (m_sec == 59) begin
        m_sec = 0;
        m_min = wrap_inc(m_min);
      end else begin
        m_sec = m_sec + 1;
      end
    end
    expect_now(0, m_st == 0);
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    compare_out(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int t_set;
    rst_n = 1'b0; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    m_min = 0; m_sec = 0; m_st = 0;
    repeat (3) step();
    expect_now(0, 1'b1);
    compare_out("reset");
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 3; i++) do_tick("run_tick");

    // reset mid-count clears in one edge
    rst_n = 1'b0;
    m_min = 0; m_sec = 0; m_st = 0;
    expect_now(0, 1'b1);
    step();
    compare_out("mid_reset");
    rst_n = 1'b1;
    step();

    // long mode hold: one press, blink alternates, ticks frozen
    t_set = -1;
    for (int e = 1; e <= 30; e++) begin
      btn_mode = (e < 20);
      tick_1hz = (e > D + 4) && (e % 5 == 0);
      step();
      tick_1hz = 1'b0;
      if (t_set < 0 && set_active) t_set = e;
      if (e == D + 4) begin
        check_val("mode_latency_ok", int'(t_set >= 1 && t_set <= D + 4), 1);
        if (t_set < 0) t_set = D + 4;
        m_st = 1;
      end
      if (e >= D + 4) begin
        expect_now((((e - t_set) / 8) % 2 == 1) ? 12 : 0, 1'b1);
        compare_out("hold_blink");
      end
    end
    btn_mode = 1'b0;
    repeat (10) step();

    for (int i = 0; i < 59; i++) do_press("inc_min", 1'b0, 1'b1);
    do_press("inc_min_wrap", 1'b0, 1'b1);
    do_press("to_set_sec", 1'b1, 1'b0);
    for (int i = 0; i < 59; i++) do_press("inc_sec", 1'b0, 1'b1);
    do_press("inc_sec_wrap", 1'b0, 1'b1);
    do_press("to_run", 1'b1, 1'b0);
    do_press("to_set_min", 1'b1, 1'b0);
    for (int i = 0; i < 59; i++) do_press("preload_min", 1'b0, 1'b1);

    // short glitch is filtered
    expect_now(0, 1'b0);
    btn_inc = 1'b1;
    repeat (2) step();
    btn_inc = 1'b0;
    repeat (12) step();
    compare_out("glitch");

    do_press("mode_inc_same", 1'b1, 1'b1);
    for (int i = 0; i < 58; i++) do_press("preload_sec", 1'b0, 1'b1);
    do_press("preload_run", 1'b1, 1'b0);
    do_tick("tick_5959");
    do_tick("tick_0000");

    // tick coincident with the mode press pulse
    btn_mode = 1'b1;
    repeat (D + 2) step();
    m_sec = m_sec + 1;
    m_st  = 1;
    expect_now(0, 1'b1);
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    compare_out("tick_mode_same");
    btn_mode = 1'b0;
    repeat (12) step();
    expect_now(0, 1'b0);
    compare_out("after_tick_mode");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
